// File: rtl/gate_tt_sequencer_pkg.sv
// Shared encodings for the gate truth-table sequencer: state codes, vector sizing
// and the standard 2-input gate truth tables (bit index = {a,b}).
package gate_seq_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    DRIVE  = S_DRIVE,
    SETTLE = S_SETTLE,
    SAMPLE = S_SAMPLE,
    DONE   = S_DONE
  } state_t;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic tt_lookup(input logic [3:0] tt, input logic [VEC_W-1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Control/result bundle between the sequencer (slave) and whoever starts it and
// hosts the gate under test (master). All outputs are registered in the sequencer.
// start is a level sampled only in IDLE; no ready/ack, busy/done report progress.
interface gate_tt_sequencer_if;
  import gate_seq_pkg::*;

  logic             start;
  logic             abort;
  logic             y_i;
  logic             a_o;
  logic             b_o;
  logic [VEC_W-1:0] vec_idx;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       fail_mask;
  logic [2:0]       state;

  modport slave (
    input  start, abort, y_i,
    output a_o, b_o, vec_idx, busy, done, pass, fail_mask, state
  );

  modport master (
    output start, abort, y_i,
    input  a_o, b_o, vec_idx, busy, done, pass, fail_mask, state
  );
endinterface

// File: rtl/gate_tt_sequencer_settle_counter.sv
// 4-bit settle down-counter; expired is high on the last cycle of the settle window.
module gate_settle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  input  logic [3:0] load_value,
  output logic       expired
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // <=1 so a stray zero load can never hold the FSM in SETTLE forever
  assign expired = (count <= 4'd1);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps a 2-input gate through {a,b}=00..11, compares y against TRUTH_TABLE and
// reports per-vector mismatches in fail_mask plus an overall pass flag.
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_NOR,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_tt_sequencer_if.slave   bus
);

  localparam logic [3:0]       SETTLE_LOAD = SETTLE_CYCLES[3:0];
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);
  localparam state_t           AFTER_DRIVE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t           state;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic [VEC_W-1:0] vec_q;
  logic [3:0]       mask_q;
  logic [3:0]       mask_next;
  logic             settle_expired;

  gate_settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == DRIVE),
    .enable     (state == SETTLE),
    .load_value (SETTLE_LOAD),
    .expired    (settle_expired)
  );

  always_comb begin
    mask_next        = mask_q;
    mask_next[vec_q] = mask_q[vec_q] | (bus.y_i != tt_lookup(TRUTH_TABLE, vec_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      vec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      mask_q <= 4'd0;
    end else if (bus.abort && state != IDLE) begin
      // partial fail_mask is deliberately kept for post-mortem
      state  <= IDLE;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            state  <= DRIVE;
            vec_q  <= '0;
            mask_q <= 4'd0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        DRIVE: begin
          {a_q, b_q} <= vec_q;
          state      <= AFTER_DRIVE;
        end
        SETTLE: begin
          if (settle_expired) state <= SAMPLE;
        end
        SAMPLE: begin
          mask_q <= mask_next;
          if (vec_q == LAST_VEC) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            pass_q <= ~|mask_next;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
          end else begin
            vec_q <= vec_q + 1'b1;
            state <= DRIVE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: one DUT with SETTLE_CYCLES=2 and a selectable
// gate model, one with SETTLE_CYCLES=0 wired to a NOR gate.
module tb_gate_tt_sequencer;
  import gate_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [1:0] gsel;  // 0: NOR, 1: tied 0, 2: OR

  gate_tt_sequencer_if bus2 ();
  gate_tt_sequencer_if bus0 ();

  gate_tt_sequencer #(.TRUTH_TABLE(TT_NOR), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );
  gate_tt_sequencer #(.TRUTH_TABLE(TT_NOR), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate models
  always_comb begin
    case (gsel)
      2'd0:    bus2.y_i = ~(bus2.a_o | bus2.b_o);
      2'd1:    bus2.y_i = 1'b0;
      default: bus2.y_i = bus2.a_o | bus2.b_o;
    endcase
    bus0.y_i = ~(bus0.a_o | bus0.b_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one sweep on dut2, returns edges from accept to done and sampled {a,b} order
  task automatic sweep2(output int cycles, output logic [7:0] ab_seq, output logic busy_seen);
    logic got;
    got = 1'b0; cycles = 0; ab_seq = 8'h00;
    @(negedge clk) bus2.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus2.start = 1'b0;
    busy_seen = bus2.busy;
    while (!got && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus2.state == S_SAMPLE) ab_seq = {ab_seq[5:0], bus2.a_o, bus2.b_o};
      if (bus2.done) got = 1'b1;
    end
  endtask

  initial begin
    int          cyc;
    int          dones;
    logic [7:0]  seq;
    logic        bsy;
    logic        found;

    vectors = 0; miscompares = 0;
    gsel = 2'd0;
    rst_n = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state: {state,a,b,vec,busy,done,pass,mask}
    check("reset_dut2", {bus2.state, bus2.a_o, bus2.b_o, bus2.vec_idx, bus2.busy,
                         bus2.done, bus2.pass, bus2.fail_mask}, 32'h0);
    check("reset_dut0", {bus0.state, bus0.a_o, bus0.b_o, bus0.vec_idx, bus0.busy,
                         bus0.done, bus0.pass, bus0.fail_mask}, 32'h0);

    // 1: NOR gate, correct table
    sweep2(cyc, seq, bsy);
    check("t1_busy", bsy, 1);
    check("t1_latency", cyc, 16);
    check("t1_pass", bus2.pass, 1);
    check("t1_mask", bus2.fail_mask, 4'b0000);
    check("t1_busy_done", bus2.busy, 0);
    check("t1_ab_idle", {bus2.a_o, bus2.b_o}, 2'b00);
    @(negedge clk);
    check("t1_done_pulse", bus2.done, 0);
    check("t1_pass_held", bus2.pass, 1);

    // 2: y tied low -> only vector 0 (expects 1) mismatches
    gsel = 2'd1;
    sweep2(cyc, seq, bsy);
    check("t2_latency", cyc, 16);
    check("t2_pass", bus2.pass, 0);
    check("t2_mask", bus2.fail_mask, 4'b0001);

    // 3: OR gate against NOR table -> all mismatch, vectors in order
    gsel = 2'd2;
    sweep2(cyc, seq, bsy);
    check("t3_pass", bus2.pass, 0);
    check("t3_mask", bus2.fail_mask, 4'b1111);
    check("t3_ab_seq", seq, 8'b00_01_10_11);

    // 4: zero settle, start re-pulsed while busy
    @(negedge clk) bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk) bus0.start = 1'b0;
    cyc = 0; dones = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus0.start = (cyc == 3);
      if (bus0.done) begin found = 1'b1; dones++; end
    end
    bus0.start = 1'b0;
    check("t4_latency", cyc, 8);
    check("t4_pass", bus0.pass, 1);
    check("t4_mask", bus0.fail_mask, 4'b0000);
    repeat (20) begin
      @(negedge clk);
      if (bus0.done) dones++;
    end
    check("t4_single_done", dones, 1);
    check("t4_idle", bus0.state, S_IDLE);

    // abort together with start in IDLE: stays idle
    @(negedge clk) begin bus2.start = 1'b1; bus2.abort = 1'b1; end
    @(negedge clk) begin bus2.start = 1'b0; bus2.abort = 1'b0; end
    check("abort_start_idle", {bus2.state, bus2.busy}, 4'h0);

    // 5: abort in SETTLE of vector 2 (OR gate -> vectors 0,1 already failed)
    gsel = 2'd2;
    @(negedge clk) bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      if (bus2.state == S_SETTLE && bus2.vec_idx == 2'd2) found = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    check("t5_reach_settle2", found, 1);
    bus2.abort = 1'b1;
    @(negedge clk) bus2.abort = 1'b0;
    check("t5_state", bus2.state, S_IDLE);
    check("t5_outs", {bus2.busy, bus2.done, bus2.a_o, bus2.b_o, bus2.pass}, 5'b0);
    check("t5_mask", bus2.fail_mask, 4'b0011);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus2.done) dones++;
    end
    check("t5_no_done", dones, 0);

    // 6: reset during SAMPLE of vector 1, then a clean sweep
    gsel = 2'd0;
    @(negedge clk) bus2.start = 1'b1;
    @(negedge clk) bus2.start = 1'b0;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      if (bus2.state == S_SAMPLE && bus2.vec_idx == 2'd1) found = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    check("t6_reach_sample1", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_reset", {bus2.state, bus2.a_o, bus2.b_o, bus2.vec_idx, bus2.busy,
                             bus2.done, bus2.pass, bus2.fail_mask}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    sweep2(cyc, seq, bsy);
    check("t6_latency", cyc, 16);
    check("t6_pass", bus2.pass, 1);
    check("t6_mask", bus2.fail_mask, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
